// File: rtl/rob_pkg.sv
// Shared reorder-buffer types, default sizes and elaboration-time parameter checks.
package rob_pkg;

  localparam int unsigned RobDepth = 32;
  localparam int unsigned RobXlen  = 32;
  localparam int unsigned RobPregW = 5;

  typedef struct packed {
    logic                valid;
    logic                done;
    logic [RobPregW-1:0] prd_addr;
    logic [RobXlen-1:0]  pc;
    logic [RobXlen-1:0]  inst;
    logic [RobXlen-1:0]  value;
  } rob_entry_t;

  function automatic int unsigned idx_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic bit depth_ok(input int unsigned depth);
    return (depth >= 4) && ((depth & (depth - 1)) == 0);
  endfunction

  function automatic bit commit_width_ok(input int unsigned width, input int unsigned depth);
    return (width >= 1) && (width <= 4) && (width <= depth);
  endfunction

endpackage

// File: rtl/rob_commit_sel.sv
// Picks up to COMMIT_WIDTH consecutive valid&done entries starting at head.
module rob_commit_sel
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH        = RobDepth,
  parameter int unsigned COMMIT_WIDTH = 2,
  localparam int unsigned IDX_W       = idx_w(DEPTH)
) (
  input  logic [IDX_W-1:0]              head,
  input  logic [DEPTH-1:0]              valid,
  input  logic [DEPTH-1:0]              done,
  output logic [COMMIT_WIDTH-1:0]       commit_mask,
  output logic [COMMIT_WIDTH*IDX_W-1:0] slot_idx
);

  logic run;

  // Prefix-AND: the first entry not ready stops every younger slot.
  always_comb begin
    commit_mask = '0;
    slot_idx    = '0;
    run         = 1'b1;
    for (int j = 0; j < int'(COMMIT_WIDTH); j++) begin
      slot_idx[j*IDX_W +: IDX_W] = head + IDX_W'(j);
      run = run & valid[slot_idx[j*IDX_W +: IDX_W]] & done[slot_idx[j*IDX_W +: IDX_W]];
      commit_mask[j] = run;
    end
  end

endmodule

// File: rtl/rob_mc.sv
// Multi-writeback, multi-commit reorder buffer.
// Optional flush port and logic are built only when ROB_FLUSH_EN is defined.
module rob_mc
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH        = RobDepth,
  parameter int unsigned WB_PORTS     = 3,
  parameter int unsigned COMMIT_WIDTH = 2,
  parameter int unsigned XLEN         = RobXlen,
  parameter int unsigned PREG_W       = RobPregW,
  localparam int unsigned IDX_W       = idx_w(DEPTH),
  localparam int unsigned PTR_W       = IDX_W + 1
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
`ifdef ROB_FLUSH_EN
  input  logic                           flush_i,
`endif
  input  logic                           alloc_valid_i,
  input  logic [PREG_W-1:0]              prd_addr_i,
  input  logic [XLEN-1:0]                pc_i,
  input  logic [XLEN-1:0]                inst_i,
  output logic [IDX_W-1:0]               rob_idx_o,
  output logic                           alloc_ready_o,
  input  logic [WB_PORTS-1:0]            wb_valid_i,
  input  logic [WB_PORTS*IDX_W-1:0]      wb_idx_i,
  input  logic [WB_PORTS*XLEN-1:0]       wb_value_i,
  output logic                           empty_o,
  output logic                           full_o,
  output logic [IDX_W:0]                 count_o,
  output logic [COMMIT_WIDTH-1:0]        commit_valid_o,
  output logic [COMMIT_WIDTH*XLEN-1:0]   commit_inst_o,
  output logic [COMMIT_WIDTH*XLEN-1:0]   commit_pc_o,
  output logic [COMMIT_WIDTH*PREG_W-1:0] commit_prd_addr_o,
  output logic [COMMIT_WIDTH*XLEN-1:0]   commit_value_o
);

  if (!depth_ok(DEPTH) || !commit_width_ok(COMMIT_WIDTH, DEPTH)) begin : g_param_err
    $error("rob_mc: DEPTH must be a power of two >= 4 and COMMIT_WIDTH in 1..4");
  end

  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [PTR_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  n_commit;
  logic [DEPTH-1:0]  valid_q, valid_d, done_q, done_d;
  logic [PREG_W-1:0] prd_q   [DEPTH];
  logic [XLEN-1:0]   pc_q    [DEPTH];
  logic [XLEN-1:0]   inst_q  [DEPTH];
  logic [XLEN-1:0]   value_q [DEPTH];

  logic                           flush;
  logic                           alloc_acc;
  logic [IDX_W-1:0]               tail_idx;
  logic [COMMIT_WIDTH-1:0]        sel_mask;
  logic [COMMIT_WIDTH*IDX_W-1:0]  slot_idx;
  logic [IDX_W-1:0]               wb_idx  [WB_PORTS];
  logic [XLEN-1:0]                wb_val  [WB_PORTS];
  logic [WB_PORTS-1:0]            wb_take;

`ifdef ROB_FLUSH_EN
  assign flush = flush_i;
`else
  assign flush = 1'b0;
`endif

  assign tail_idx      = tail_q[IDX_W-1:0];
  assign rob_idx_o     = tail_idx;
  assign empty_o       = (head_q == tail_q);
  assign full_o        = (head_q[IDX_W] != tail_q[IDX_W]) &&
                         (head_q[IDX_W-1:0] == tail_q[IDX_W-1:0]);
  assign alloc_ready_o = ~full_o;
  assign count_o       = count_q;
  assign alloc_acc     = alloc_valid_i & ~full_o & ~flush;

  for (genvar k = 0; k < int'(WB_PORTS); k++) begin : g_wb
    assign wb_idx[k]  = wb_idx_i[k*IDX_W +: IDX_W];
    assign wb_val[k]  = wb_value_i[k*XLEN +: XLEN];
    assign wb_take[k] = wb_valid_i[k] & valid_q[wb_idx[k]] & ~flush;
  end

  rob_commit_sel #(
    .DEPTH        (DEPTH),
    .COMMIT_WIDTH (COMMIT_WIDTH)
  ) u_commit_sel (
    .head        (head_q[IDX_W-1:0]),
    .valid       (valid_q),
    .done        (done_q),
    .commit_mask (sel_mask),
    .slot_idx    (slot_idx)
  );

  assign commit_valid_o = flush ? '0 : sel_mask;

  always_comb begin
    commit_inst_o     = '0;
    commit_pc_o       = '0;
    commit_prd_addr_o = '0;
    commit_value_o    = '0;
    for (int j = 0; j < int'(COMMIT_WIDTH); j++) begin
      if (commit_valid_o[j]) begin
        commit_inst_o[j*XLEN +: XLEN]       = inst_q[slot_idx[j*IDX_W +: IDX_W]];
        commit_pc_o[j*XLEN +: XLEN]         = pc_q[slot_idx[j*IDX_W +: IDX_W]];
        commit_prd_addr_o[j*PREG_W +: PREG_W] = prd_q[slot_idx[j*IDX_W +: IDX_W]];
        commit_value_o[j*XLEN +: XLEN]      = value_q[slot_idx[j*IDX_W +: IDX_W]];
      end
    end
  end

  always_comb begin
    valid_d  = valid_q;
    done_d   = done_q;
    n_commit = '0;
    for (int k = 0; k < int'(WB_PORTS); k++) begin
      if (wb_take[k]) done_d[wb_idx[k]] = 1'b1;
    end
    for (int j = 0; j < int'(COMMIT_WIDTH); j++) begin
      if (commit_valid_o[j]) begin
        valid_d[slot_idx[j*IDX_W +: IDX_W]] = 1'b0;
        done_d[slot_idx[j*IDX_W +: IDX_W]]  = 1'b0;
      end
      n_commit = n_commit + PTR_W'(commit_valid_o[j]);
    end
    if (alloc_acc) begin
      valid_d[tail_idx] = 1'b1;
      done_d[tail_idx]  = 1'b0;
    end
    head_d  = head_q + n_commit;
    tail_d  = tail_q + PTR_W'(alloc_acc);
    count_d = count_q + PTR_W'(alloc_acc) - n_commit;
    if (flush) begin
      valid_d = '0;
      done_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  // Payload needs no reset: outputs are gated by valid. Highest port is written first so
  // the lowest-numbered port's value lands last and wins a same-index conflict.
  always_ff @(posedge clk_i) begin
    for (int k = int'(WB_PORTS) - 1; k >= 0; k--) begin
      if (wb_take[k]) value_q[wb_idx[k]] <= wb_val[k];
    end
    if (alloc_acc) begin
      prd_q[tail_idx]   <= prd_addr_i;
      pc_q[tail_idx]    <= pc_i;
      inst_q[tail_idx]  <= inst_i;
      value_q[tail_idx] <= '0;
    end
  end

endmodule

// File: tb/tb_rob_mc.sv
// Directed bench for rob_mc with a queue-based reference model checked every cycle.
module tb_rob_mc;

  localparam int DEPTH = 32;
  localparam int WBP   = 3;
  localparam int CW    = 2;
  localparam int XLEN  = 32;
  localparam int PW    = 5;
  localparam int IW    = 5;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              flush = 1'b0;
  logic              alloc_valid = 1'b0;
  logic [PW-1:0]     prd = '0;
  logic [XLEN-1:0]   pc = '0;
  logic [XLEN-1:0]   inst = '0;
  logic [IW-1:0]     rob_idx;
  logic              alloc_ready;
  logic [WBP-1:0]    wb_valid = '0;
  logic [WBP*IW-1:0] wb_idx = '0;
  logic [WBP*XLEN-1:0] wb_value = '0;
  logic              empty, full;
  logic [IW:0]       count;
  logic [CW-1:0]     c_valid;
  logic [CW*XLEN-1:0] c_inst, c_pc, c_value;
  logic [CW*PW-1:0]  c_prd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rob_mc u_dut (
    .clk_i             (clk),
    .reset_ni          (reset_n),
`ifdef ROB_FLUSH_EN
    .flush_i           (flush),
`endif
    .alloc_valid_i     (alloc_valid),
    .prd_addr_i        (prd),
    .pc_i              (pc),
    .inst_i            (inst),
    .rob_idx_o         (rob_idx),
    .alloc_ready_o     (alloc_ready),
    .wb_valid_i        (wb_valid),
    .wb_idx_i          (wb_idx),
    .wb_value_i        (wb_value),
    .empty_o           (empty),
    .full_o            (full),
    .count_o           (count),
    .commit_valid_o    (c_valid),
    .commit_inst_o     (c_inst),
    .commit_pc_o       (c_pc),
    .commit_prd_addr_o (c_prd),
    .commit_value_o    (c_value)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: program-order queue of occupied indices plus per-index payload.
  int            mq[$];
  int            m_tail;
  bit            m_done [DEPTH];
  logic [PW-1:0] m_prd  [DEPTH];
  logic [31:0]   m_pc   [DEPTH];
  logic [31:0]   m_inst [DEPTH];
  logic [31:0]   m_val  [DEPTH];

  function automatic int exp_ncommit();
    int n = 0;
    if (flush) return 0;
    while (n < CW && n < mq.size() && m_done[mq[n]]) n++;
    return n;
  endfunction

  task automatic mreset();
    mq.delete();
    m_tail = 0;
    foreach (m_done[i]) m_done[i] = 1'b0;
  endtask

  always @(posedge clk or negedge reset_n) begin : mdl
    int n, pre, idx;
    bit inq [DEPTH];
    bit claim [DEPTH];
    if (!reset_n || flush) begin
      mreset();
    end else begin
      n   = exp_ncommit();
      pre = mq.size();
      foreach (inq[i]) begin
        inq[i]   = 1'b0;
        claim[i] = 1'b0;
      end
      foreach (mq[i]) inq[mq[i]] = 1'b1;
      for (int k = 0; k < WBP; k++) begin
        idx = int'(wb_idx[k*IW +: IW]);
        if (wb_valid[k] && inq[idx] && !claim[idx]) begin
          claim[idx]  = 1'b1;
          m_done[idx] = 1'b1;
          m_val[idx]  = wb_value[k*XLEN +: XLEN];
        end
      end
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (alloc_valid && pre < DEPTH) begin
        mq.push_back(m_tail);
        m_done[m_tail] = 1'b0;
        m_prd[m_tail]  = prd;
        m_pc[m_tail]   = pc;
        m_inst[m_tail] = inst;
        m_val[m_tail]  = '0;
        m_tail = (m_tail + 1) % DEPTH;
      end
    end
  end

  always @(negedge clk) begin : cmp
    int n;
    logic [CW-1:0]      ev;
    logic [CW*PW-1:0]   eprd;
    logic [CW*XLEN-1:0] epc, einst, eval;
    n = exp_ncommit();
    ev = '0; eprd = '0; epc = '0; einst = '0; eval = '0;
    for (int j = 0; j < n; j++) begin
      ev[j]                 = 1'b1;
      eprd[j*PW +: PW]      = m_prd[mq[j]];
      epc[j*XLEN +: XLEN]   = m_pc[mq[j]];
      einst[j*XLEN +: XLEN] = m_inst[mq[j]];
      eval[j*XLEN +: XLEN]  = m_val[mq[j]];
    end
    chk("m_empty", empty, mq.size() == 0);
    chk("m_full", full, mq.size() == DEPTH);
    chk("m_ready", alloc_ready, mq.size() != DEPTH);
    chk("m_count", count, mq.size());
    chk("m_rob_idx", rob_idx, m_tail);
    chk("m_cvalid", c_valid, ev);
    chk("m_cprd", c_prd, eprd);
    chk("m_cpc", c_pc, epc);
    chk("m_cinst", c_inst, einst);
    chk("m_cvalue", c_value, eval);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input int p, input logic [31:0] pcv, input logic [31:0] iv);
    alloc_valid = 1'b1;
    prd  = p[PW-1:0];
    pc   = pcv;
    inst = iv;
  endtask

  task automatic set_wb(input int port, input int idx, input logic [31:0] v);
    wb_valid[port]                = 1'b1;
    wb_idx[port*IW +: IW]         = idx[IW-1:0];
    wb_value[port*XLEN +: XLEN]   = v;
  endtask

  task automatic wait_empty(input string nm, input int lim);
    int n;
    n = 0;
    while (!empty && n < lim) begin
      tick();
      n++;
    end
    chk(nm, empty, 1);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : drive
    logic [CW*PW-1:0] eprd;
    #3;
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    chk("rst_rob_idx", rob_idx, 0);
    chk("rst_cvalid", c_valid, 0);
    chk("rst_cvalue", c_value, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    tick();

    // Async reset mid-operation.
    for (int i = 0; i < 5; i++) begin
      do_alloc(i + 1, 32'h100 + 4 * i, 32'hA0 + i);
      tick();
    end
    alloc_valid = 1'b0;
    set_wb(0, 0, 32'h55); set_wb(1, 1, 32'h66);
    tick();
    wb_valid = '0;
    chk("a_count5", count, 5);
    chk("a_cvalid_pre", c_valid, 2'b11);
    #2 reset_n = 1'b0;
    #1;
    chk("a_rst_empty", empty, 1);
    chk("a_rst_count", count, 0);
    chk("a_rst_cvalid", c_valid, 0);
    #3 reset_n = 1'b1;
    tick();

    // Fill to full, then overflow attempts.
    for (int i = 0; i < 32; i++) begin
      do_alloc(i, 32'h1000 + 4 * i, 32'hB000 + i);
      tick();
    end
    alloc_valid = 1'b0;
    chk("b_full", full, 1);
    chk("b_count32", count, 32);
    chk("b_rob_idx", rob_idx, 0);
    do_alloc(7, 32'hDEAD, 32'hDEAD);
    tick();
    alloc_valid = 1'b0;
    chk("b_33_count", count, 32);
    chk("b_33_rob_idx", rob_idx, 0);
    set_wb(0, 0, 32'hC000); set_wb(1, 1, 32'hC001); set_wb(2, 2, 32'hC002);
    tick();
    wb_valid = '0;
    chk("b_cvalid", c_valid, 2'b11);
    // Commit frees slots this cycle but the alloc is still dropped.
    do_alloc(9, 32'hBEEF, 32'hBEEF);
    set_wb(0, 3, 32'hC003); set_wb(1, 4, 32'hC004); set_wb(2, 5, 32'hC005);
    tick();
    alloc_valid = 1'b0;
    wb_valid = '0;
    chk("b_count30", count, 30);
    for (int b = 6; b < 32; b += 3) begin
      for (int p = 0; p < 3; p++) if (b + p < 32) set_wb(p, b + p, 32'hC000 + b + p);
      tick();
      wb_valid = '0;
    end
    wait_empty("b_drain", 40);

    // Out-of-order writeback.
    for (int i = 0; i < 4; i++) begin
      do_alloc(10 + i, 32'h2000 + 4 * i, 32'hC0 + i);
      tick();
    end
    alloc_valid = 1'b0;
    set_wb(2, 3, 32'h33); set_wb(1, 2, 32'h22); set_wb(0, 1, 32'h11);
    tick();
    wb_valid = '0;
    chk("c_blocked", c_valid, 2'b00);
    set_wb(0, 0, 32'h10);
    tick();
    wb_valid = '0;
    chk("c_cv_first", c_valid, 2'b11);
    chk("c_val01", c_value, {32'h11, 32'h10});
    tick();
    chk("c_cv_second", c_valid, 2'b11);
    eprd = {5'd13, 5'd12};
    chk("c_prd23", c_prd, eprd);
    chk("c_val23", c_value, {32'h33, 32'h22});
    tick();
    chk("c_empty", empty, 1);

    // Writeback port conflict.
    chk("d_rob_idx", rob_idx, 4);
    do_alloc(17, 32'h3000, 32'hD0);
    tick();
    alloc_valid = 1'b0;
    set_wb(0, 4, 32'hAAAA); set_wb(1, 4, 32'h5555);
    tick();
    wb_valid = '0;
    chk("d_cvalid", c_valid, 2'b01);
    chk("d_value", c_value, 64'hAAAA);
    tick();
    chk("d_empty", empty, 1);

    // Advance to head=tail=30, then commit across the wrap.
    for (int i = 0; i < 25; i++) begin
      do_alloc(i, 32'h4000 + 4 * i, i);
      tick();
    end
    alloc_valid = 1'b0;
    for (int b = 5; b < 30; b += 3) begin
      for (int p = 0; p < 3; p++) if (b + p < 30) set_wb(p, b + p, b + p);
      tick();
      wb_valid = '0;
    end
    wait_empty("e_drain", 40);
    chk("e_rob_idx30", rob_idx, 30);
    for (int i = 0; i < 4; i++) begin
      do_alloc(20 + i, 32'h5000 + 4 * i, 32'hE0 + i);
      tick();
    end
    alloc_valid = 1'b0;
    chk("e_rob_idx2", rob_idx, 2);
    chk("e_count4", count, 4);
    set_wb(0, 30, 32'h30); set_wb(1, 31, 32'h31); set_wb(2, 0, 32'h40);
    tick();
    wb_valid = '0;
    set_wb(0, 1, 32'h41);
    chk("e_cv_a", c_valid, 2'b11);
    eprd = {5'd21, 5'd20};
    chk("e_prd_a", c_prd, eprd);
    tick();
    wb_valid = '0;
    chk("e_cv_b", c_valid, 2'b11);
    eprd = {5'd23, 5'd22};
    chk("e_prd_b", c_prd, eprd);
    chk("e_pc_b", c_pc, {32'h500C, 32'h5008});
    tick();
    chk("e_empty", empty, 1);

`ifdef ROB_FLUSH_EN
    for (int i = 0; i < 6; i++) begin
      do_alloc(i, 32'h6000 + 4 * i, 32'hF0 + i);
      tick();
    end
    alloc_valid = 1'b0;
    set_wb(0, 2, 32'h1); set_wb(1, 3, 32'h2);
    tick();
    wb_valid = '0;
    chk("f_cv_pre", c_valid, 2'b11);
    flush = 1'b1;
    do_alloc(5, 32'h7000, 32'h7000);
    #1;
    chk("f_cv_flush", c_valid, 2'b00);
    tick();
    flush = 1'b0;
    alloc_valid = 1'b0;
    chk("f_empty", empty, 1);
    chk("f_rob_idx", rob_idx, 0);
    chk("f_count", count, 0);
    tick();
    chk("f_cv_after", c_valid, 2'b00);
`endif

    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
